// File: rtl/b_type_pkg.sv
// b_type_pkg
//   Shared definitions for the sequential branch unit: the branch opcode, the
//   funct3 condition codes, the 2-bit counter states and the saturating
//   counter update used by the branch history table.
package b_type_pkg;

  localparam logic [6:0] BRANCH_OP = 7'b1100011;

  // funct3 values 2 and 3 have no branch meaning and are reported as illegal.
  typedef enum logic [2:0] {
    F3_BEQ  = 3'd0,
    F3_BNE  = 3'd1,
    F3_BLT  = 3'd4,
    F3_BGE  = 3'd5,
    F3_BLTU = 3'd6,
    F3_BGEU = 3'd7
  } br_funct3_e;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bht_state_e;

  // Move one step toward the observed outcome, sticking at SNT and ST.
  function automatic bht_state_e sat_update(input bht_state_e state, input logic taken);
    bht_state_e next;
    next = state;
    case (state)
      SNT: next = taken ? WNT : SNT;
      WNT: next = taken ? WT  : SNT;
      WT:  next = taken ? ST  : WNT;
      ST:  next = taken ? ST  : WT;
      default: next = WNT;
    endcase
    return next;
  endfunction

endpackage

// File: rtl/b_type_bht.sv
// b_type_bht
//   Table of 2-bit saturating branch counters.
//   Ports:
//     clk, rst_n   clock and asynchronous active-low reset (all entries -> WNT)
//     rd_idx       fetch-side index, asynchronous read
//     rd_state     counter at rd_idx (value before any same-cycle write)
//     wr_en        apply a resolved outcome this cycle
//     wr_idx       EX-side index to update
//     wr_taken     resolved direction, counter moves one step toward it
module b_type_bht
  import b_type_pkg::*;
#(
  parameter  int ENTRIES = 64,
  localparam int IDX_W   = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] rd_idx,
  output bht_state_e       rd_state,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_taken
);

  bht_state_e r_table [ENTRIES];

  // The read is purely combinational from the register array, so a fetch
  // that hits the entry being written this cycle sees the old counter.
  assign rd_state = r_table[rd_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_table[i] <= WNT;
      end
    end else if (wr_en) begin
      r_table[wr_idx] <= sat_update(r_table[wr_idx], wr_taken);
    end
  end

endmodule

// File: rtl/b_type_bpu.sv
// b_type_bpu
//   Resolves conditional branches in EX, predicts at fetch from a table of
//   2-bit counters, and issues a registered one-cycle redirect on mispredict.
//   Ports:
//     clk, rst_n         clock and asynchronous active-low reset
//     if_pc              fetch PC; if_pred_taken is the counter MSB for it
//     ex_valid, opcode   EX instruction valid and its opcode
//     funct3, imm        branch condition and B-type offset (bit 0 ignored)
//     in1, in2           rs1/rs2 operands
//     pc                 EX instruction PC
//     ex_pred_taken      direction predicted at fetch for this instruction
//     redirect_valid     registered mispredict pulse
//     redirect_pc        registered correct next PC (holds between redirects)
//     illegal_br         registered pulse for funct3 2/3 branches
//   Configuration:
//     B_TYPE_STATS_EN    adds stat_branches / stat_mispredicts saturating counters
module b_type_bpu
  import b_type_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int BHT_ENTRIES = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] if_pc,
  output logic            if_pred_taken,
  input  logic            ex_valid,
  input  logic [6:0]      opcode,
  input  logic [2:0]      funct3,
  input  logic [12:0]     imm,
  input  logic [XLEN-1:0] in1,
  input  logic [XLEN-1:0] in2,
  input  logic [XLEN-1:0] pc,
  input  logic            ex_pred_taken,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            illegal_br
`ifdef B_TYPE_STATS_EN
  ,
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_mispredicts
`endif
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);

  logic            r_redirect_valid;
  logic [XLEN-1:0] r_redirect_pc;
  logic            r_illegal_br;

  logic            w_accepted;
  logic            w_legal;
  logic            w_taken;
  logic            w_update;
  logic            w_mispredict;
  logic [XLEN-1:0] w_target;
  logic [XLEN-1:0] w_fallthrough;
  bht_state_e      w_if_state;
  logic            w_unused_bits;

  // Fetch PC bits outside the index and the always-zero offset bit are unused.
  assign w_unused_bits = ^{imm[0], if_pc[XLEN-1:IDX_W+2], if_pc[1:0]};

  b_type_bht #(
    .ENTRIES (BHT_ENTRIES)
  ) u_bht (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_idx   (if_pc[IDX_W+1:2]),
    .rd_state (w_if_state),
    .wr_en    (w_update),
    .wr_idx   (pc[IDX_W+1:2]),
    .wr_taken (w_taken)
  );

  assign if_pred_taken = w_if_state[1];

  // While a redirect is out, the EX instruction is on the wrong path.
  assign w_accepted = ex_valid && (opcode == BRANCH_OP) && !r_redirect_valid;
  assign w_legal    = (funct3 != 3'd2) && (funct3 != 3'd3);

  always_comb begin
    w_taken = 1'b0;
    case (funct3)
      F3_BEQ:  w_taken = (in1 == in2);
      F3_BNE:  w_taken = (in1 != in2);
      F3_BLT:  w_taken = ($signed(in1) <  $signed(in2));
      F3_BGE:  w_taken = ($signed(in1) >= $signed(in2));
      F3_BLTU: w_taken = (in1 <  in2);
      F3_BGEU: w_taken = (in1 >= in2);
      default: w_taken = 1'b0;
    endcase
  end

  assign w_target      = pc + {{(XLEN-13){imm[12]}}, imm[12:1], 1'b0};
  assign w_fallthrough = pc + XLEN'(4);

  assign w_update     = w_accepted && w_legal;
  assign w_mispredict = w_update && (w_taken != ex_pred_taken);

  // Redirect and illegal flags are single-cycle pulses; the redirect PC is
  // only loaded on a mispredict so it keeps the last correction otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= '0;
      r_illegal_br     <= 1'b0;
    end else begin
      r_redirect_valid <= w_mispredict;
      r_illegal_br     <= w_accepted && !w_legal;
      if (w_mispredict) begin
        r_redirect_pc <= w_taken ? w_target : w_fallthrough;
      end
    end
  end

  assign redirect_valid = r_redirect_valid;
  assign redirect_pc    = r_redirect_pc;
  assign illegal_br     = r_illegal_br;

`ifdef B_TYPE_STATS_EN
  logic [31:0] r_stat_branches;
  logic [31:0] r_stat_mispredicts;

  // Event counters follow the table update timing and stick at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_branches    <= '0;
      r_stat_mispredicts <= '0;
    end else begin
      if (w_update && (r_stat_branches != 32'hFFFF_FFFF)) begin
        r_stat_branches <= r_stat_branches + 32'd1;
      end
      if (w_mispredict && (r_stat_mispredicts != 32'hFFFF_FFFF)) begin
        r_stat_mispredicts <= r_stat_mispredicts + 32'd1;
      end
    end
  end

  assign stat_branches    = r_stat_branches;
  assign stat_mispredicts = r_stat_mispredicts;
`endif

endmodule

// File: tb/tb_b_type_bpu.sv
// tb_b_type_bpu
//   Self-checking bench for b_type_bpu: directed scenarios followed by random
//   branches, compared against a behavioural model of the counter table and
//   the redirect/illegal outputs.
module tb_b_type_bpu;

  localparam int XLEN    = 32;
  localparam int ENTRIES = 64;
  localparam logic [6:0] BR = 7'b1100011;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [XLEN-1:0] if_pc;
  logic            if_pred_taken;
  logic            ex_valid;
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [12:0]     imm;
  logic [XLEN-1:0] in1;
  logic [XLEN-1:0] in2;
  logic [XLEN-1:0] pc;
  logic            ex_pred_taken;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            illegal_br;
`ifdef B_TYPE_STATS_EN
  logic [31:0]     stat_branches;
  logic [31:0]     stat_mispredicts;
`endif

  int nCompared   = 0;
  int nMismatched = 0;

  // Reference state: counters as small integers 0..3, plus output shadows.
  int          mTable [ENTRIES];
  bit          mRv;
  logic [31:0] mRpc;
  bit          mIll;
  int unsigned mBranches;
  int unsigned mMispredicts;

  always #5 clk = ~clk;

  b_type_bpu #(
    .XLEN        (XLEN),
    .BHT_ENTRIES (ENTRIES)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .if_pc          (if_pc),
    .if_pred_taken  (if_pred_taken),
    .ex_valid       (ex_valid),
    .opcode         (opcode),
    .funct3         (funct3),
    .imm            (imm),
    .in1            (in1),
    .in2            (in2),
    .pc             (pc),
    .ex_pred_taken  (ex_pred_taken),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .illegal_br     (illegal_br)
`ifdef B_TYPE_STATS_EN
    ,
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts)
`endif
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nCompared++;
    if (observed !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  function automatic int idxOf(input logic [31:0] addr);
    return int'((addr / 4) % ENTRIES);
  endfunction

  function automatic bit refTaken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    int     sa;
    int     sb;
    longint ua;
    longint ub;
    sa = a;
    sb = b;
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    case (f3)
      3'd0:    return a == b;
      3'd1:    return a != b;
      3'd4:    return sa < sb;
      3'd5:    return sa >= sb;
      3'd6:    return ua < ub;
      3'd7:    return ua >= ub;
      default: return 1'b0;
    endcase
  endfunction

  task automatic modelReset();
    for (int i = 0; i < ENTRIES; i++) mTable[i] = 1;
    mRv          = 1'b0;
    mRpc         = '0;
    mIll         = 1'b0;
    mBranches    = 0;
    mMispredicts = 0;
  endtask

  // One EX cycle: drive after the falling edge, check the fetch prediction
  // before the rising edge, advance the model at the edge, check outputs after.
  task automatic applyStimulus(input bit v, input logic [6:0] op, input logic [2:0] f3,
                               input logic [12:0] im, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] p, input bit pr, input logic [31:0] ip);
    bit          acc;
    bit          legal;
    bit          tk;
    int          off;
    logic [31:0] tgt;
    logic [31:0] ft;
    @(negedge clk);
    ex_valid      = v;
    opcode        = op;
    funct3        = f3;
    imm           = im;
    in1           = a;
    in2           = b;
    pc            = p;
    ex_pred_taken = pr;
    if_pc         = ip;
    #1;
    checkOutput("if_pred_taken", {31'd0, if_pred_taken}, {31'd0, mTable[idxOf(ip)] >= 2});
    acc   = v && (op == BR) && !mRv;
    legal = (f3 != 3'd2) && (f3 != 3'd3);
    tk    = legal && refTaken(f3, a, b);
    off   = $signed(im);
    off   = off & ~1;
    tgt   = p + off;
    ft    = p + 32'd4;
    @(posedge clk);
    mIll = acc && !legal;
    mRv  = 1'b0;
    if (acc && legal) begin
      if (mBranches != 32'hFFFF_FFFF) mBranches++;
      if (tk) mTable[idxOf(p)] = (mTable[idxOf(p)] < 3) ? mTable[idxOf(p)] + 1 : 3;
      else    mTable[idxOf(p)] = (mTable[idxOf(p)] > 0) ? mTable[idxOf(p)] - 1 : 0;
      if (tk != pr) begin
        mRv  = 1'b1;
        mRpc = tk ? tgt : ft;
        if (mMispredicts != 32'hFFFF_FFFF) mMispredicts++;
      end
    end
    #1;
    checkOutput("redirect_valid", {31'd0, redirect_valid}, {31'd0, mRv});
    checkOutput("redirect_pc", redirect_pc, mRpc);
    checkOutput("illegal_br", {31'd0, illegal_br}, {31'd0, mIll});
`ifdef B_TYPE_STATS_EN
    checkOutput("stat_branches", stat_branches, mBranches);
    checkOutput("stat_mispredicts", stat_mispredicts, mMispredicts);
`endif
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 7'd0, 3'd0, 13'd0, 32'd0, 32'd0, 32'd0, 1'b0, 32'd0);
  endtask

  // Walk the fetch PC over every index; EX is idle so edges change nothing.
  task automatic scanTable(input string tag);
    ex_valid = 1'b0;
    for (int i = 0; i < ENTRIES; i++) begin
      if_pc = 32'(i * 4);
      #1;
      checkOutput(tag, {31'd0, if_pred_taken}, {31'd0, mTable[i] >= 2});
    end
  endtask

  initial begin
    logic [31:0] r;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] p;
    logic [31:0] ip;
    logic [6:0]  op;
    bit          pr;

    rst_n = 1'b0;
    ex_valid = 1'b0; opcode = '0; funct3 = '0; imm = '0;
    in1 = '0; in2 = '0; pc = '0; ex_pred_taken = 1'b0; if_pc = '0;
    modelReset();
    #12;
    checkOutput("reset_redirect_valid", {31'd0, redirect_valid}, 32'd0);
    checkOutput("reset_redirect_pc", redirect_pc, 32'd0);
    checkOutput("reset_illegal_br", {31'd0, illegal_br}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    scanTable("reset_table");

    // Scenario 1: BEQ taken, predicted not-taken.
    applyStimulus(1'b1, BR, 3'd0, 13'h010, 32'd1, 32'd1, 32'h100, 1'b0, 32'h100);
    checkOutput("t1_redirect_valid", {31'd0, redirect_valid}, 32'd1);
    checkOutput("t1_redirect_pc", redirect_pc, 32'h110);
    idleCycle();
    // Scenario 2: same branch, predicted taken, twice.
    applyStimulus(1'b1, BR, 3'd0, 13'h010, 32'd1, 32'd1, 32'h100, 1'b1, 32'h100);
    checkOutput("t2_no_redirect", {31'd0, redirect_valid}, 32'd0);
    applyStimulus(1'b1, BR, 3'd0, 13'h010, 32'd1, 32'd1, 32'h100, 1'b1, 32'h100);
    idleCycle();
    scanTable("t2_table");

    // Scenario 3: BLT signed taken, BLTU same operands not-taken.
    applyStimulus(1'b1, BR, 3'd4, 13'h020, 32'hFFFF_FFFF, 32'd0, 32'h200, 1'b1, 32'h200);
    checkOutput("t3_blt_taken", {31'd0, redirect_valid}, 32'd0);
    applyStimulus(1'b1, BR, 3'd6, 13'h020, 32'hFFFF_FFFF, 32'd0, 32'h204, 1'b1, 32'h204);
    checkOutput("t3_bltu_redirect_pc", redirect_pc, 32'h208);
    idleCycle();

    // Scenario 4: target wraps past the top of the address space.
    applyStimulus(1'b1, BR, 3'd0, 13'h008, 32'd5, 32'd5, 32'hFFFF_FFFC, 1'b0, 32'h0);
    checkOutput("t4_wrap_pc", redirect_pc, 32'h0000_0004);
    // Scenario 5: branch in the redirect cycle is ignored.
    applyStimulus(1'b1, BR, 3'd0, 13'h010, 32'd1, 32'd1, 32'h300, 1'b0, 32'h300);
    checkOutput("t5_ignored", {31'd0, redirect_valid}, 32'd0);
    idleCycle();
    scanTable("t5_table");

    // Scenario 6: illegal funct3, then a non-branch opcode.
    applyStimulus(1'b1, BR, 3'd3, 13'h010, 32'd1, 32'd1, 32'h400, 1'b0, 32'h400);
    checkOutput("t6_illegal", {31'd0, illegal_br}, 32'd1);
    applyStimulus(1'b1, 7'd0, 3'd0, 13'h010, 32'd1, 32'd1, 32'h400, 1'b0, 32'h400);
    checkOutput("t6_quiet", {31'd0, illegal_br | redirect_valid}, 32'd0);

    // Random traffic concentrated on a handful of indices to hit saturation.
    for (int n = 0; n < 400; n++) begin
      r  = $urandom;
      a  = $urandom;
      b  = (r[0]) ? a : ((r[1]) ? $urandom : $urandom_range(0, 3));
      p  = $urandom;
      if (r[2]) p = (p & 32'hFFFF_FF00) | 32'($urandom_range(0, 7) * 4);
      p  = p & 32'hFFFF_FFFC;
      op = (r[5:3] != 3'd0) ? BR : 7'($urandom);
      ip = (r[6]) ? p : $urandom;
      pr = (r[7]) ? (mTable[idxOf(p)] >= 2) : r[8];
      applyStimulus(r[12:9] != 4'd0, op, 3'($urandom_range(0, 7)), 13'($urandom),
                    a, b, p, pr, ip);
    end
    idleCycle();
    scanTable("random_table");

    // Asynchronous reset with a redirect pending.
    applyStimulus(1'b1, BR, 3'd1, 13'h040, 32'd1, 32'd2, 32'h500, 1'b0, 32'h500);
    checkOutput("pre_reset_redirect", {31'd0, redirect_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    modelReset();
    checkOutput("async_redirect_valid", {31'd0, redirect_valid}, 32'd0);
    checkOutput("async_redirect_pc", redirect_pc, 32'd0);
    checkOutput("async_illegal_br", {31'd0, illegal_br}, 32'd0);
    scanTable("async_table");
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b1, BR, 3'd5, 13'h1FF0, 32'd3, 32'd3, 32'h600, 1'b0, 32'h600);
    checkOutput("post_reset_back_pc", redirect_pc, 32'h5F0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
